load_unit: RTL



---
 rtl/load_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/load_unit.sv
// ---------------------------------------------------------------------------
// load_unit
//   Load-side memory reader for the MEM stage of the pipelined CPU. Accepts one
//   load at a time, issues an aligned 64-bit read over a req/ack handshake,
//   extracts the addressed byte/half/word/double (little-endian), sign- or
//   zero-extends it and returns it for writeback. Misaligned requests and
//   memory timeouts are reported with a one-cycle err pulse.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   ld_valid   : MEM stage presents a load this cycle
//   ld_addr    : byte address
//   ld_size    : 0 byte, 1 half, 2 word, 3 double
//   ld_signed  : 1 sign-extend, 0 zero-extend (ignored for double)
//   ld_rd      : destination register
//   stall      : combinational, freezes the upstream pipeline
//   mem_req    : read request to data memory (high for every WAIT cycle)
//   mem_addr   : ld_addr with bits [2:0] cleared, stable while mem_req is high
//   mem_ack    : memory returns mem_rdata this cycle (only honoured in WAIT)
//   mem_rdata  : 64-bit read data
//   wb_valid   : one-cycle pulse, wb_data/wb_rd valid
//   wb_data    : extended load result, held between pulses
//   wb_rd      : destination register, held between pulses
//   err        : one-cycle pulse on misaligned access or timeout
// ---------------------------------------------------------------------------
module load_unit #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [4:0]        ld_rd,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata,
  output logic              wb_valid,
  output logic [63:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [CNT_W-1:0] waitCnt;
  logic             aligned;
  logic             cntExpired;
  logic             acceptLoad;
  logic             captureData;
  logic             errNext;

  // Attributes of the outstanding load, latched when it is accepted
  logic [2:0]       offsetReg;
  logic [1:0]       sizeReg;
  logic             signedReg;
  logic [4:0]       rdReg;

  logic [63:0]      shifted;
  logic [63:0]      extracted;

  // Natural alignment check: address must be a multiple of the access size
  always_comb begin
    aligned = 1'b0;
    case (ld_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = (ld_addr[0] == 1'b0);
      2'd2:    aligned = (ld_addr[1:0] == 2'b00);
      2'd3:    aligned = (ld_addr[2:0] == 3'b000);
      default: aligned = 1'b0;
    endcase
  end

  assign cntExpired = (waitCnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; an ack on the expiring cycle still completes the load
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (ld_valid && aligned) begin
          nextState = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          nextState = DONE;
        end else if (cntExpired) begin
          nextState = IDLE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Combinational outputs and register-update strobes
  always_comb begin
    stall       = 1'b0;
    acceptLoad  = 1'b0;
    captureData = 1'b0;
    errNext     = 1'b0;
    case (state)
      IDLE: begin
        stall      = ld_valid & aligned;
        acceptLoad = ld_valid & aligned;
        errNext    = ld_valid & ~aligned;
      end
      WAIT: begin
        stall       = 1'b1;
        captureData = mem_ack;
        errNext     = ~mem_ack & cntExpired;
      end
      DONE: begin
        stall = 1'b0;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  // Select and extend the addressed field of the returned doubleword
  always_comb begin
    shifted   = mem_rdata >> {offsetReg, 3'b000};
    extracted = shifted;
    case (sizeReg)
      2'd0:    extracted = {{56{signedReg & shifted[7]}},  shifted[7:0]};
      2'd1:    extracted = {{48{signedReg & shifted[15]}}, shifted[15:0]};
      2'd2:    extracted = {{32{signedReg & shifted[31]}}, shifted[31:0]};
      2'd3:    extracted = shifted;
      default: extracted = shifted;
    endcase
  end

  // WAIT-cycle counter, restarted on every accepted load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCnt <= '0;
    end else if (acceptLoad) begin
      waitCnt <= '0;
    end else if (state == WAIT) begin
      waitCnt <= waitCnt + CNT_W'(1);
    end
  end

  // Latched request attributes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offsetReg <= 3'b000;
      sizeReg   <= 2'b00;
      signedReg <= 1'b0;
      rdReg     <= 5'd0;
    end else if (acceptLoad) begin
      offsetReg <= ld_addr[2:0];
      sizeReg   <= ld_size;
      signedReg <= ld_signed;
      rdReg     <= ld_rd;
    end
  end

  // Registered interface outputs; request/valid follow the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      wb_valid <= 1'b0;
      wb_data  <= 64'd0;
      wb_rd    <= 5'd0;
      err      <= 1'b0;
    end else begin
      mem_req  <= (nextState == WAIT);
      wb_valid <= (nextState == DONE);
      err      <= errNext;
      if (acceptLoad) begin
        mem_addr <= {ld_addr[ADDR_W-1:3], 3'b000};
      end
      // wb_rd is only updated alongside wb_data so both hold between pulses
      if (captureData) begin
        wb_data <= extracted;
        wb_rd   <= rdReg;
      end
    end
  end

endmodule
